// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - round-robin arbiter with registered one-hot grant and hold timeout
//
// Purpose: shares one resource among N requesters. A winner is picked
// round-robin starting at the pointer. Its grant is held until the owner
// asserts done, drops its request, or holds it for MAX_HOLD cycles.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-high
//   i_req[N]     request per requester
//   i_done       owner releases the resource (used only while a grant is active)
//   o_gnt[N]     registered one-hot grant
//   o_gnt_idx    binary index of the granted requester, 0 when idle
//   o_gnt_valid  a grant is active
//   o_timeout    one-cycle pulse after a release forced purely by hold expiry
module rr_arbiter8 #(
   parameter int N        = 8,
   parameter int IDXW     = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N-1:0]    i_req,
   input  logic            i_done,
   output logic [N-1:0]    o_gnt,
   output logic [IDXW-1:0] o_gnt_idx,
   output logic            o_gnt_valid,
   output logic            o_timeout
);

   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N-1:0]    r_gnt;
   logic [N-1:0]    w_gnt_nxt;
   logic [IDXW-1:0] r_idx;
   logic [IDXW-1:0] w_idx_nxt;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] w_ptr_nxt;
   logic [HW-1:0]   r_hold;
   logic [HW-1:0]   w_hold_nxt;
   logic            r_timeout;
   logic            w_timeout_nxt;

   logic            w_found;
   logic [IDXW-1:0] w_win;
   logic [IDXW-1:0] w_cand;
   logic            w_expire;
   logic            w_owner_req;
   logic            w_release;

   // Scan from the highest offset down so the last hit is the closest
   // requester at or after r_ptr. IDXW-bit addition wraps naturally since
   // N is a power of two.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_cand = r_ptr + IDXW'(k);
         if (i_req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   assign w_expire    = (r_hold == HW'(MAX_HOLD - 1));
   assign w_owner_req = i_req[r_idx];
   assign w_release   = i_done | ~w_owner_req | w_expire;

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_idx_nxt     = r_idx;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = BUSY;
               w_gnt_nxt   = N'(1) << w_win;
               w_idx_nxt   = w_win;
               w_ptr_nxt   = w_win + IDXW'(1);
               w_hold_nxt  = '0;
            end
         end
         BUSY: begin
            if (w_release) begin
               w_state_nxt   = IDLE;
               w_gnt_nxt     = '0;
               w_idx_nxt     = '0;
               w_hold_nxt    = '0;
               // A coincident done or request drop makes this a normal release.
               w_timeout_nxt = w_expire & ~i_done & w_owner_req;
            end else begin
               w_hold_nxt = r_hold + HW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_idx     <= '0;
         r_ptr     <= '0;
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_idx     <= w_idx_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hold    <= w_hold_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_idx   = r_idx;
   assign o_gnt_valid = |r_gnt;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       to;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int n_vec;
   int n_miss;

   vec_t tbl[$];
   vec_t exp_q[$];

   rr_arbiter8 #(.N(8), .IDXW(3), .MAX_HOLD(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_done      (done),
      .o_gnt       (gnt),
      .o_gnt_idx   (gnt_idx),
      .o_gnt_valid (gnt_valid),
      .o_timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] encode(input logic [7:0] g);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (g[i]) r = 3'(i);
      return r;
   endfunction

   function automatic vec_t mk(input logic r, input logic [7:0] q, input logic d,
                               input logic [7:0] g, input logic [2:0] x, input logic t);
      vec_t v;
      v.rst = r; v.req = q; v.done = d; v.gnt = g; v.idx = x; v.to = t;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at vector %0d: got %h, expected %h", name, n_vec, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue the expected post-edge outputs,
   // then pop and compare them 1 time unit after the edge.
   task automatic step(input vec_t v);
      vec_t e;
      rst  = v.rst;
      req  = v.req;
      done = v.done;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      chk("gnt", gnt, e.gnt);
      chk("gnt_idx", {5'd0, gnt_idx}, {5'd0, e.idx});
      chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, |e.gnt});
      chk("timeout", {7'd0, timeout}, {7'd0, e.to});
      chk("onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
      chk("idx_encode", {5'd0, gnt_idx}, {5'd0, encode(gnt)});
   endtask

   initial begin
      logic [7:0] g;
      n_vec  = 0;
      n_miss = 0;
      rst    = 1'b1;
      req    = 8'h00;
      done   = 1'b0;
      #1;

      // Reset with all requests pending, then first grant goes to 0.
      tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 3'd0, 0));
      tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 3'd0, 0));
      tbl.push_back(mk(0, 8'hFF, 0, 8'h01, 3'd0, 0));
      // Full rotation 1..7 then wrap to 0, one idle cycle between owners.
      for (int k = 1; k <= 8; k++) begin
         g = 8'h01 << (k % 8);
         tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 3'd0, 0));
         tbl.push_back(mk(0, 8'hFF, 0, g, 3'(k % 8), 0));
      end
      // Grant 2 so ptr=3, then 8'h24 gives 5, then wraps to 2.
      tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 3'd0, 0));
      tbl.push_back(mk(0, 8'h04, 0, 8'h04, 3'd2, 0));
      tbl.push_back(mk(0, 8'h04, 1, 8'h00, 3'd0, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h20, 3'd5, 0));
      tbl.push_back(mk(0, 8'h24, 1, 8'h00, 3'd0, 0));
      tbl.push_back(mk(0, 8'h24, 0, 8'h04, 3'd2, 0));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0));

      foreach (tbl[i]) step(tbl[i]);

      // Hold expiry: ptr=3, req 8'h08 held -> 4 grant cycles, timeout, re-grant.
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h08, 0, 8'h00, 3'd0, 1));
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      // done coincides with expiry on the 4th grant cycle -> no timeout.
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h08, 1, 8'h00, 3'd0, 0));
      // Owner drops its request mid-grant -> normal release.
      step(mk(0, 8'h08, 0, 8'h08, 3'd3, 0));
      step(mk(0, 8'h00, 0, 8'h00, 3'd0, 0));
      step(mk(0, 8'h00, 0, 8'h00, 3'd0, 0));
      // Reset during a grant to 6 clears ptr: 8'hC1 then picks 0, not 7.
      step(mk(0, 8'h40, 0, 8'h40, 3'd6, 0));
      step(mk(1, 8'h40, 0, 8'h00, 3'd0, 0));
      step(mk(0, 8'hC1, 0, 8'h01, 3'd0, 0));
      // Non-owner request changes while busy leave the grant alone.
      step(mk(0, 8'hFF, 0, 8'h01, 3'd0, 0));
      step(mk(0, 8'hFE, 0, 8'h00, 3'd0, 0));
      step(mk(0, 8'hFE, 0, 8'h02, 3'd1, 0));

      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
